// File: rtl/textrow_fetch.sv
// Fetches one text row of attribute/code words into a double-buffered row buffer.
// Optional TEXTROW_FETCH_TIMEOUT_EN substitutes 16'h0000 for words whose ack never arrives.
module textrow_fetch #(
    parameter int COLS       = 100,
    parameter int ROW_STRIDE = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  row_index,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        wr,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        bank,
    output logic        busy,
    output logic        done,
`ifdef TEXTROW_FETCH_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);

    state_t      state;
    logic [11:0] base;
    logic [6:0]  col;
    logic [6:0]  col_next;
    logic [11:0] base_new;
    logic        take;
    logic [15:0] take_data;

    assign base_new = 12'(int'(row_index) * ROW_STRIDE);
    assign col_next = col + 7'd1;

`ifdef TEXTROW_FETCH_TIMEOUT_EN
    logic [3:0] tcnt;
    logic       tmo_hit;

    // 15th unacknowledged REQ cycle: give up on this word and write zero.
    assign tmo_hit = (state == REQ) && !mem_ack && (tcnt == 4'd14);

    always_comb begin
        take      = mem_ack | tmo_hit;
        take_data = mem_ack ? mem_data : 16'h0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt    <= 4'd0;
            timeout <= 1'b0;
        end else begin
            if (state != REQ || take) tcnt <= 4'd0;
            else                      tcnt <= tcnt + 4'd1;
            if (tmo_hit) timeout <= 1'b1;
        end
    end
`else
    always_comb begin
        take      = mem_ack;
        take_data = mem_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base     <= 12'd0;
            col      <= 7'd0;
            mem_req  <= 1'b0;
            mem_addr <= 12'd0;
            wr       <= 1'b1;
            wr_addr  <= 8'd0;
            wr_data  <= 16'd0;
            bank     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    base     <= base_new;
                    col      <= 7'd0;
                    mem_addr <= base_new;
                    mem_req  <= 1'b1;
                    busy     <= 1'b1;
                    state    <= REQ;
                end
                REQ: if (take) begin
                    wr_data <= take_data;
                    mem_req <= 1'b0;
                    wr      <= 1'b0;
                    wr_addr <= {~bank, col};
                    state   <= WRITE;
                end
                WRITE: begin
                    wr <= 1'b1;
                    if (col == LAST_COL) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        bank  <= ~bank;
                    end else begin
                        col      <= col_next;
                        mem_addr <= base + 12'(col_next);
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_textrow_fetch.sv
// Directed bench for textrow_fetch: table of full-row fetches plus hand-written
// sequences for slow ack, overrun, start-on-done and mid-fetch reset.
module tb_textrow_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  row_index = 6'd0;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        wr;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        bank, busy, done, overrun;
`ifdef TEXTROW_FETCH_TIMEOUT_EN
    logic        timeout;
`endif

    textrow_fetch dut (
        .clk(clk), .rst(rst), .start(start), .row_index(row_index),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .bank(bank), .busy(busy), .done(done),
`ifdef TEXTROW_FETCH_TIMEOUT_EN
        .timeout(timeout),
`endif
        .overrun(overrun)
    );

    always #12 clk = ~clk;

    // Memory model: data = address; one address may be made slow.
    logic [11:0] slow_addr = 12'hFFF;
    int          slow_dly  = 0;
    int          req_cyc   = 0;
    assign mem_data = {4'h0, mem_addr};
    assign mem_ack  = mem_req && ((mem_addr != slow_addr) || (req_cyc >= slow_dly));
    always @(posedge clk) begin
        if (mem_req && !mem_ack) req_cyc <= req_cyc + 1;
        else                     req_cyc <= 0;
    end

    // Write/done/request monitor
    logic [7:0]  wq_a[$];
    logic [15:0] wq_d[$];
    int          dcnt = 0, run = 0, maxrun = 0, achg = 0;
    logic        prev_req = 1'b0;
    logic [11:0] prev_addr = 12'd0;
    initial forever begin
        @(negedge clk);
        if (!wr) begin
            wq_a.push_back(wr_addr);
            wq_d.push_back(wr_data);
        end
        if (done) dcnt++;
        if (mem_req) begin
            if (prev_req && mem_addr != prev_addr) achg++;
            run++;
            if (run > maxrun) maxrun = run;
        end else run = 0;
        prev_req  = mem_req;
        prev_addr = mem_addr;
    end

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        wq_a.delete();
        wq_d.delete();
        dcnt = 0; maxrun = 0; achg = 0;
    endtask

    // Wait for done with a cycle bound; returns negedge count since start drive.
    task automatic wait_done(input int bound, inout int cyc);
        int n;
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            cyc++; n++;
            if (cyc == 1) start = 1'b0;
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic run_row(input logic [5:0] r, output int cyc);
        clear_mon();
        @(negedge clk);
        start = 1'b1; row_index = r;
        cyc = 0;
        wait_done(2000, cyc);
    endtask

    // Count mismatches against a linear addr/data ramp; skip_col gets data 0.
    task automatic chk_writes(input string nm, input logic [7:0] a0, input logic [15:0] d0,
                              input int zero_col);
        int bad;
        logic [7:0]  ea;
        logic [15:0] ed;
        bad = 0;
        chk({nm, "_count"}, wq_a.size(), 100);
        for (int i = 0; i < wq_a.size() && i < 100; i++) begin
            ea = a0 + 8'(i);
            ed = (i == zero_col) ? 16'h0000 : d0 + 16'(i);
            if (wq_a[i] != ea || wq_d[i] != ed) bad++;
        end
        chk({nm, "_seq"}, bad, 0);
    endtask

    typedef struct {
        logic [5:0]  row;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic        bank_after;
        int          cyc;
    } vec_t;
    vec_t tv[4];

    initial begin
        int cyc, n;
        tv[0] = '{6'd2,  8'h80, 16'h0100, 1'b1, 201};
        tv[1] = '{6'd3,  8'h00, 16'h0180, 1'b0, 201};
        tv[2] = '{6'd63, 8'h80, 16'h0F80, 1'b1, 201};
        tv[3] = '{6'd32, 8'h00, 16'h0000, 1'b0, 201};

        repeat (3) @(negedge clk);
        chk("rst_wr", int'(wr), 1);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_bank", int'(bank), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_row(tv[i].row, cyc);
            chk($sformatf("row%0d_done_cyc", i), cyc, tv[i].cyc);
            @(negedge clk);
            chk_writes($sformatf("row%0d", i), tv[i].a0, tv[i].d0, -1);
            chk($sformatf("row%0d_bank", i), int'(bank), int'(tv[i].bank_after));
            chk($sformatf("row%0d_busy", i), int'(busy), 0);
            chk($sformatf("row%0d_dcnt", i), dcnt, 1);
        end

        // Slow ack on column 7: address held for 6 cycles.
        slow_addr = 12'h107; slow_dly = 5;
        run_row(6'd2, cyc);
        chk("slow_done_cyc", cyc, 206);
        @(negedge clk);
        chk_writes("slow", 8'h80, 16'h0100, -1);
        chk("slow_maxrun", maxrun, 6);
        chk("slow_addr_stable", achg, 0);
        slow_addr = 12'hFFF; slow_dly = 0;

        // Overrun mid-fetch, then start on the done cycle (bank is 1 here).
        clear_mon();
        @(negedge clk);
        start = 1'b1; row_index = 6'd2;
        @(negedge clk); start = 1'b0;
        repeat (49) @(negedge clk);
        start = 1'b1; row_index = 6'd9;
        @(negedge clk); start = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        cyc = 1;
        wait_done(2000, cyc);
        start = 1'b1; row_index = 6'd3;
        @(negedge clk); start = 1'b0;
        chk("ovr_count", wq_a.size(), 100);
        chk("ovr_dcnt", dcnt, 1);
        chk("ovr_first_addr", int'(wq_a[0]), 8'h00);
        chk("ondone_busy", int'(busy), 1);
        chk("ondone_addr", int'(mem_addr), 12'h180);
        clear_mon();
        cyc = 1;
        wait_done(2000, cyc);
        @(negedge clk);
        chk_writes("ondone", 8'h80, 16'h0180, -1);
        chk("ondone_bank", int'(bank), 1);

        // Reset at column 40.
        clear_mon();
        @(negedge clk);
        start = 1'b1; row_index = 6'd2;
        n = 0;
        while (n < 2000) begin
            @(negedge clk); start = 1'b0; #1;
            n++;
            if (wq_a.size() >= 40) break;
        end
        chk("rst_reach_col40", int'(wq_a.size() >= 40), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr", int'(wr), 1);
        chk("arst_mem_req", int'(mem_req), 0);
        chk("arst_mem_addr", int'(mem_addr), 0);
        chk("arst_wr_addr", int'(wr_addr), 0);
        chk("arst_wr_data", int'(wr_data), 0);
        chk("arst_bank", int'(bank), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_overrun", int'(overrun), 0);
        n = wq_a.size();
        repeat (5) @(negedge clk);
        chk("arst_no_write", wq_a.size(), n);
        rst = 1'b0;
        run_row(6'd5, cyc);
        @(negedge clk);
        chk_writes("post_rst", 8'h80, 16'h0280, -1);

`ifdef TEXTROW_FETCH_TIMEOUT_EN
        chk("tmo_clear", int'(timeout), 0);
        slow_addr = 12'h10A; slow_dly = 100000;
        run_row(6'd2, cyc);
        chk("tmo_done_cyc", cyc, 215);
        @(negedge clk);
        chk_writes("tmo", 8'h00, 16'h0100, 10);
        chk("tmo_maxrun", maxrun, 15);
        chk("tmo_flag", int'(timeout), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
